// File: rtl/result_wb_pkg.sv
// Shared types and helpers for the result write-back stage: FSM states,
// lane slicing and unsigned pixel saturation.
package result_wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } wb_state_e;

  // Saturation is evaluated at this fixed width so one function serves any lane/pixel size.
  localparam int SAT_CALC_W = 64;

  function automatic int lane_lsb(input int lane, input int lane_w);
    return lane * lane_w;
  endfunction

  function automatic logic [SAT_CALC_W-1:0] pix_max(input int pix_w);
    return (SAT_CALC_W'(1) << pix_w) - SAT_CALC_W'(1);
  endfunction

  function automatic logic exceeds(input logic [SAT_CALC_W-1:0] lane, input int pix_w);
    return lane > pix_max(pix_w);
  endfunction

  function automatic logic [SAT_CALC_W-1:0] saturate(input logic [SAT_CALC_W-1:0] lane,
                                                     input int pix_w);
    return exceeds(lane, pix_w) ? pix_max(pix_w) : lane;
  endfunction

endpackage

// File: rtl/result_writeback_sync_fifo.sv
// Generic synchronous show-ahead FIFO: the head entry is readable while empty_o is low.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i && !full_o) wr_d = wr_q + (AW+1)'(1);
    if (pop_i && !empty_o) rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/result_writeback.sv
// Accepts rows of PE results, saturates each lane to a pixel and writes pixels to RAM
// one per cycle at consecutive addresses. Optional macro: RESULT_WB_SATCOUNT_EN.
module result_writeback
  import result_wb_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 6,
  parameter int RAM_DATA_WIDTH = 8,
  parameter int PE_DATA_WIDTH  = 16,
  parameter int DEPTH          = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int BASE_ADDR      = 0,
  parameter int ROWS_WIDTH     = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [ROWS_WIDTH-1:0]          num_rows,
  input  logic                           in_valid,
  input  logic [PE_DATA_WIDTH*DEPTH-1:0] in_data,
  output logic                           in_ready,
  output logic                           ram_we,
  output logic [RAM_ADDR_WIDTH-1:0]      ram_addr,
  output logic [RAM_DATA_WIDTH-1:0]      ram_wdata,
  output logic                           busy,
  output logic                           done,
  output logic [RAM_ADDR_WIDTH:0]        sat_count
);
  localparam int LCW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW  = PE_DATA_WIDTH * DEPTH;

  wb_state_e                 state_q, state_d;
  logic [ROWS_WIDTH-1:0]     num_rows_q, num_rows_d;
  logic [ROWS_WIDTH-1:0]     rows_q, rows_d;
  logic [RAM_ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [LCW-1:0]            lane_q, lane_d;
  logic                      ram_we_q, ram_we_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [RAM_DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;

  logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [RW-1:0]             fifo_head;
  logic [PE_DATA_WIDTH-1:0]  lanes [DEPTH];
  logic [SAT_CALC_W-1:0]     cur_lane;
  logic                      ser_active, last_lane;

  sync_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (in_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lane
    assign lanes[gi] = fifo_head[lane_lsb(gi, PE_DATA_WIDTH) +: PE_DATA_WIDTH];
  end

  assign cur_lane   = SAT_CALC_W'(lanes[lane_q]);
  assign last_lane  = (lane_q == LCW'(DEPTH - 1));
  assign ser_active = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !fifo_empty;
  // Push looks only at full, never at a same-cycle pop, to keep in_ready off the pop path.
  assign fifo_push  = (state_q == S_RUN) && in_valid && !fifo_full;
  assign fifo_pop   = ser_active && last_lane;

  assign in_ready  = (state_q == S_RUN) && !fifo_full;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign ram_we    = ram_we_q && !reset;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  always_comb begin
    state_d     = state_q;
    num_rows_d  = num_rows_q;
    rows_d      = rows_q;
    wptr_d      = wptr_q;
    lane_d      = lane_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_rows != '0) begin
            num_rows_d = num_rows;
            rows_d     = '0;
            wptr_d     = RAM_ADDR_WIDTH'(BASE_ADDR);
            state_d    = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (fifo_push) begin
          rows_d = rows_q + ROWS_WIDTH'(1);
          if (rows_d == num_rows_q) state_d = S_DRAIN;
        end
      end
      // Waiting for ram_we_q to clear means the final write has been presented.
      S_DRAIN: begin
        if (fifo_empty && !ram_we_q && (lane_q == '0)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (ser_active) begin
      ram_we_d    = 1'b1;
      ram_addr_d  = wptr_q;
      ram_wdata_d = RAM_DATA_WIDTH'(saturate(cur_lane, RAM_DATA_WIDTH));
      wptr_d      = wptr_q + RAM_ADDR_WIDTH'(1);
      lane_d      = last_lane ? '0 : lane_q + LCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      num_rows_q  <= '0;
      rows_q      <= '0;
      wptr_q      <= RAM_ADDR_WIDTH'(BASE_ADDR);
      lane_q      <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= RAM_ADDR_WIDTH'(BASE_ADDR);
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      num_rows_q  <= num_rows_d;
      rows_q      <= rows_d;
      wptr_q      <= wptr_d;
      lane_q      <= lane_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

`ifdef RESULT_WB_SATCOUNT_EN
  logic [RAM_ADDR_WIDTH:0] sat_q;
  logic                    sat_clr;

  assign sat_clr   = (state_q == S_IDLE) && start;
  assign sat_count = sat_q;

  always_ff @(posedge clk) begin
    if (reset || sat_clr) begin
      sat_q <= '0;
    end else if (ser_active && exceeds(cur_lane, RAM_DATA_WIDTH)) begin
      sat_q <= sat_q + (RAM_ADDR_WIDTH+1)'(1);
    end
  end
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench for result_writeback: vector table, hand-written corner
// sequences and randomized jobs checked against a row-level reference model.
module tb_result_writeback;
  localparam int AW = 6, DW = 8, PW = 16, D = 4, RWID = 5;

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic [RWID-1:0]   num_rows;
  logic [PW*D-1:0]   in_data;
  logic              in_ready, ram_we, busy, done;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic [AW:0]       sat_count;
  logic              in_ready_w, ram_we_w, busy_w, done_w;
  logic [AW-1:0]     ram_addr_w;
  logic [DW-1:0]     ram_wdata_w;
  logic [AW:0]       sat_count_w;

  result_writeback dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .busy(busy), .done(done), .sat_count(sat_count)
  );

  result_writeback #(.BASE_ADDR(62)) dut_w (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w),
    .ram_we(ram_we_w), .ram_addr(ram_addr_w), .ram_wdata(ram_wdata_w),
    .busy(busy_w), .done(done_w), .sat_count(sat_count_w)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Write monitor
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int c; } wr_t;
  wr_t cap[$];
  wr_t capw[$];
  int  cyc = 0, done_cnt = 0, done_cyc = 0, acc_cnt = 0, busy_seen = 0, ready_drop = 0;
  int  start_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (ram_we)   cap.push_back('{ram_addr, ram_wdata, cyc});
    if (ram_we_w) capw.push_back('{ram_addr_w, ram_wdata_w, cyc});
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (in_valid && in_ready) acc_cnt++;
    if (busy) busy_seen++;
    if (busy && in_valid && !in_ready) ready_drop++;
  end

  task automatic clear_mon();
    cap.delete(); capw.delete();
    done_cnt = 0; acc_cnt = 0; busy_seen = 0; ready_drop = 0;
  endtask

  // Reference model: a pixel is the lane clipped to 255, rows written lane 0 first.
  logic [PW*D-1:0] jrows [32];

  function automatic int lane_val(input logic [PW*D-1:0] row, input int k);
    return int'((row >> (PW * k)) & 64'hFFFF);
  endfunction

  function automatic int exp_pix(input logic [PW*D-1:0] row, input int k);
    int v = lane_val(row, k);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic feed_row(input logic [PW*D-1:0] r, output bit ok);
    int t = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = r;
    while (!ok && t < 100) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; t++;
    end
  endtask

  task automatic run_job(input int n, input int max_gap, input bit hold_valid, input bit mid_start);
    bit ok;
    int t, nsat, exp_sat;
    clear_mon();
    start = 1'b1; num_rows = RWID'(n); start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0; num_rows = RWID'($urandom);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
      if (mid_start && i == 1) begin start = 1'b1; num_rows = RWID'(3); end
      feed_row(jrows[i], ok);
      start = 1'b0;
      if (!ok) check("accept_timeout", 0, 1);
      if (!hold_valid) in_valid = 1'b0;
    end
    t = 0;
    while (done_cnt == 0 && t < 300) begin @(posedge clk); #1; t++; end
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("done_pulses", done_cnt, 1);
    check("write_count", cap.size(), 4 * n);
    check("write_count_base62", capw.size(), 4 * n);
    check("rows_accepted", acc_cnt, n);
    nsat = 0;
    for (int i = 0; i < n * 4; i++) if (lane_val(jrows[i / 4], i % 4) > 255) nsat++;
    for (int i = 0; i < n * 4 && i < cap.size() && i < capw.size(); i++) begin
      check($sformatf("addr[%0d]", i), cap[i].a, (i) % 64);
      check($sformatf("data[%0d]", i), cap[i].d, exp_pix(jrows[i / 4], i % 4));
      check($sformatf("addr62[%0d]", i), capw[i].a, (62 + i) % 64);
      check($sformatf("data62[%0d]", i), capw[i].d, exp_pix(jrows[i / 4], i % 4));
    end
`ifdef RESULT_WB_SATCOUNT_EN
    exp_sat = nsat;
`else
    exp_sat = 0;
`endif
    check("sat_count", sat_count, exp_sat);
    $display("job rows=%0d writes=%0d done=%0d sat=%0d", n, cap.size(), done_cnt, sat_count);
  endtask

  typedef struct { logic [PW*D-1:0] row; logic [31:0] pix; int nsat; } vec_t;
  vec_t vecs [5];

  initial begin
    logic [31:0] pv;
    bit ok;
    int t;
    vecs[0] = '{64'hFFFF_0100_00FF_0010, 32'hFF_FF_FF_10, 2};
    vecs[1] = '{64'h0000_0000_0000_0000, 32'h00_00_00_00, 0};
    vecs[2] = '{64'h0001_00FE_0101_8000, 32'h01_FE_FF_FF, 2};
    vecs[3] = '{64'h00FF_00FF_00FF_00FF, 32'hFF_FF_FF_FF, 0};
    vecs[4] = '{64'h0200_1234_0080_007F, 32'hFF_FF_80_7F, 2};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; num_rows = '0; in_data = '0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst_ram_we", ram_we, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_addr62", ram_addr_w, 62);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat_count", sat_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Saturation vectors, one row per job
    for (int v = 0; v < 5; v++) begin
      jrows[0] = vecs[v].row;
      run_job(1, 0, 0, 0);
      pv = vecs[v].pix;
      for (int k = 0; k < 4 && k < cap.size(); k++)
        check($sformatf("vec%0d_pix%0d", v, k), cap[k].d, pv[8*k +: 8]);
`ifdef RESULT_WB_SATCOUNT_EN
      check($sformatf("vec%0d_sat", v), sat_count, vecs[v].nsat);
`endif
      if (v == 0 && cap.size() == 4) begin
        check("vec0_consecutive", cap[3].c - cap[0].c, 3);
        check("vec0_done_latency", done_cyc - cap[3].c, 2);
      end
    end

    // Backpressure: valid held high for 8 rows
    for (int i = 0; i < 8; i++) jrows[i] = {$urandom, $urandom};
    run_job(8, 0, 1, 0);
    check("bp_ready_dropped", ready_drop > 0, 1);
    if (cap.size() == 32) check("bp_continuous", cap[31].c - cap[0].c, 31);

    // Empty job
    run_job(0, 0, 0, 0);
    check("empty_busy_seen", busy_seen, 0);
    check("empty_done_next", done_cyc, start_cyc + 1);

    // Start ignored mid-job
    for (int i = 0; i < 5; i++) jrows[i] = {$urandom, $urandom};
    run_job(5, 1, 0, 1);

    // Reset mid-RUN
    clear_mon();
    start = 1'b1; num_rows = RWID'(4);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      feed_row({$urandom, $urandom}, ok);
      if (!ok) check("rst_seq_accept", 0, 1);
    end
    in_valid = 1'b0;
    t = 0;
    while (cap.size() == 0 && t < 50) begin @(posedge clk); #1; t++; end
    check("rst_seq_writing", cap.size() > 0, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_seq_we_during", ram_we, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_seq_we_after", ram_we, 0);
    check("rst_seq_ready_after", in_ready, 0);
    check("rst_seq_busy_after", busy, 0);
    @(posedge clk); #1;
    jrows[0] = 64'h0123_0456_0078_009A;
    run_job(1, 0, 0, 0);

    // Randomized jobs
    for (int j = 0; j < 10; j++) begin
      int n = $urandom_range(20, 1);
      for (int i = 0; i < n; i++)
        for (int k = 0; k < 4; k++)
          jrows[i][16*k +: 16] = ($urandom_range(1, 0) == 1) ? 16'($urandom) : 16'($urandom_range(255, 0));
      run_job(n, 3, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=0", 1);
    $fatal(1, "timeout");
  end

endmodule
